// File: rtl/clock_display_scanner.sv
// rtl/clock_display_scanner.sv - 4-digit multiplexed common-anode 7-segment scanner for HH:MM time digits
//
// Purpose:
//   Scans the four BCD time digits onto a multiplexed common-anode display.
//   The four digits are captured together into shadow registers once per full
//   scan, so a digit never changes halfway through a scan.
//   The first BLANK_TICKS cycles of every digit slot keep all anodes off, so
//   the previous digit does not ghost onto the next one.
//   The decimal point of the hour-ones digit blinks with sec_led[0] and acts
//   as the hour/minute separator.
//
// Ports:
//   CLK      in   1  system clock
//   RST      in   1  synchronous, active-high reset
//   H_1      in   4  hour tens digit (BCD)
//   H_0      in   4  hour ones digit (BCD)
//   M_1      in   4  minute tens digit (BCD)
//   M_0      in   4  minute ones digit (BCD)
//   sec_led  in   6  seconds count; only bit 0 is used (separator blink)
//   an       out  4  anode enables, active low, an[0] = rightmost digit
//   seg      out  7  segments {g,f,e,d,c,b,a}, active low
//   dp       out  1  decimal point, active low
//
// Optional build macro:
//   LEAD_ZERO_BLANK_EN - blanks the hour tens digit when it is zero.
//                        an[3] still goes low, so the scan timing is unchanged.

module clock_display_scanner #(
  parameter int DIGIT_TICKS = 100_000,
  parameter int BLANK_TICKS = 1_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] H_1,
  input  logic [3:0] H_0,
  input  logic [3:0] M_1,
  input  logic [3:0] M_0,
  input  logic [5:0] sec_led,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;

  logic [CW-1:0] slot_cnt;
  logic [1:0]    digit_idx;
  logic          load_flag;
  logic [3:0]    sh_h1, sh_h0, sh_m1, sh_m0;

  logic          slot_wrap;
  logic          blank_now;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  // Only the seconds LSB drives the separator.
  logic unused_sec;
  assign unused_sec = ^sec_led[5:1];

  assign slot_wrap = (slot_cnt == CW'(DIGIT_TICKS - 1));
  assign blank_now = (slot_cnt < CW'(BLANK_TICKS));

  always_comb begin
    cur_digit = sh_m0;
    case (digit_idx)
      2'd0: cur_digit = sh_m0;
      2'd1: cur_digit = sh_m1;
      2'd2: cur_digit = sh_h0;
      2'd3: cur_digit = sh_h1;
      default: cur_digit = sh_m0;
    endcase
  end

  // Active-low decoder; codes 10..15 light no segments.
  always_comb begin
    cur_seg = 7'b1111111;
    case (cur_digit)
      4'd0: cur_seg = 7'b1000000;
      4'd1: cur_seg = 7'b1111001;
      4'd2: cur_seg = 7'b0100100;
      4'd3: cur_seg = 7'b0110000;
      4'd4: cur_seg = 7'b0011001;
      4'd5: cur_seg = 7'b0010010;
      4'd6: cur_seg = 7'b0000010;
      4'd7: cur_seg = 7'b1111000;
      4'd8: cur_seg = 7'b0000000;
      4'd9: cur_seg = 7'b0010000;
      default: cur_seg = 7'b1111111;
    endcase
  end

  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = 7'b1111111;
    dp_nxt  = 1'b1;
    if (!blank_now) begin
      an_nxt            = 4'b1111;
      an_nxt[digit_idx] = 1'b0;
      seg_nxt           = cur_seg;
      // The separator reads sec_led live, so it blinks on time even though the digits are snapshotted.
      dp_nxt            = !((digit_idx == 2'd2) && sec_led[0]);
`ifdef LEAD_ZERO_BLANK_EN
      if ((digit_idx == 2'd3) && (sh_h1 == 4'd0)) begin
        seg_nxt = 7'b1111111;
        dp_nxt  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_cnt  <= '0;
      digit_idx <= 2'd0;
      load_flag <= 1'b1;
      sh_h1     <= 4'd0;
      sh_h0     <= 4'd0;
      sh_m1     <= 4'd0;
      sh_m0     <= 4'd0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp        <= 1'b1;
    end else begin
      if (slot_wrap) begin
        slot_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        slot_cnt  <= slot_cnt + CW'(1);
      end
      // Capture all digits together: on the first cycle out of reset and when
      // the scan wraps from index 3 back to index 0.
      if (load_flag || (slot_wrap && (digit_idx == 2'd3))) begin
        sh_h1 <= H_1;
        sh_h0 <= H_0;
        sh_m1 <= M_1;
        sh_m0 <= M_0;
      end
      load_flag <= 1'b0;
      an        <= an_nxt;
      seg       <= seg_nxt;
      dp        <= dp_nxt;
    end
  end

endmodule
